// File: rtl/axi_slice_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axi_slice_rr_arbiter
// Brief    : Round-robin arbiter with burst locking that feeds a shared,
//            registered (non-fall-through) FIFO slice on one AXI-style channel.
// Revision : 1.0 - initial release
// ============================================================================
module axi_slice_rr_arbiter #(
    parameter  int N_REQ        = 4,
    parameter  int DATA_WIDTH   = 32,
    parameter  int BUFFER_DEPTH = 2,
    localparam int IDX_WIDTH    = $clog2(N_REQ)
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [N_REQ-1:0]            req_valid_i,
    output logic [N_REQ-1:0]            req_ready_o,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_data_i,
    input  logic [N_REQ-1:0]            req_last_i,
    output logic                        valid_o,
    input  logic                        ready_i,
    output logic [DATA_WIDTH-1:0]       data_o,
    output logic                        last_o,
    output logic [IDX_WIDTH-1:0]        idx_o,
    output logic                        locked_o
);

    localparam int         c_PTR_W  = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
    localparam int         c_CNT_W  = $clog2(BUFFER_DEPTH + 1);
    localparam logic [0:0] c_IDLE   = 1'b0;
    localparam logic [0:0] c_LOCKED = 1'b1;

    logic [0:0]           r_state;
    logic [IDX_WIDTH-1:0] r_owner;
    logic [IDX_WIDTH-1:0] r_rr_ptr;

    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;
    logic [DATA_WIDTH-1:0] r_mem_data [BUFFER_DEPTH];
    logic                  r_mem_last [BUFFER_DEPTH];
    logic [IDX_WIDTH-1:0]  r_mem_idx  [BUFFER_DEPTH];

    logic [2*N_REQ-1:0]   w_rot;
    logic [IDX_WIDTH-1:0] w_off;
    logic [IDX_WIDTH:0]   w_sum;
    logic                 w_cand_found;
    logic [IDX_WIDTH-1:0] w_cand;
    logic [IDX_WIDTH-1:0] w_grant;
    logic                 w_grant_any;
    logic                 w_grant_valid;
    logic [DATA_WIDTH-1:0] w_push_data;
    logic                 w_push_last;
    logic                 w_full;
    logic                 w_can_push;
    logic                 w_push;
    logic                 w_pop;

    // Rotate the valid vector so that bit 0 is the rr_ptr requester; the lowest
    // set bit is then the offset of the round-robin candidate.
    always_comb begin
        w_rot        = {req_valid_i, req_valid_i} >> r_rr_ptr;
        w_off        = '0;
        w_cand_found = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_cand_found = 1'b1;
                w_off        = IDX_WIDTH'(k);
            end
        end
        w_sum = (IDX_WIDTH + 1)'(r_rr_ptr) + (IDX_WIDTH + 1)'(w_off);
        if (w_sum >= (IDX_WIDTH + 1)'(N_REQ)) begin
            w_sum = w_sum - (IDX_WIDTH + 1)'(N_REQ);
        end
        w_cand = w_sum[IDX_WIDTH-1:0];
    end

    assign w_grant     = (r_state == c_LOCKED) ? r_owner : w_cand;
    assign w_grant_any = (r_state == c_LOCKED) | w_cand_found;
    assign w_full      = (r_count == c_CNT_W'(BUFFER_DEPTH));
    assign w_can_push  = ~rst_i & ~w_full & w_grant_any;

    always_comb begin
        req_ready_o   = '0;
        w_grant_valid = 1'b0;
        w_push_data   = '0;
        w_push_last   = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant == IDX_WIDTH'(i)) begin
                req_ready_o[i] = w_can_push;
                w_grant_valid  = req_valid_i[i];
                w_push_data    = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
                w_push_last    = req_last_i[i];
            end
        end
    end

    assign w_push = w_can_push & w_grant_valid;
    assign w_pop  = valid_o & ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= c_IDLE;
            r_owner  <= '0;
            r_rr_ptr <= '0;
        end else if (w_push) begin
            if (w_push_last) begin
                r_state  <= c_IDLE;
                r_rr_ptr <= (w_grant == IDX_WIDTH'(N_REQ - 1)) ? '0 : w_grant + IDX_WIDTH'(1);
            end else begin
                r_state <= c_LOCKED;
                r_owner <= w_grant;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_PTR_W'(BUFFER_DEPTH - 1)) ? '0 : r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_PTR_W'(BUFFER_DEPTH - 1)) ? '0 : r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: empty slots are never presented downstream.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= w_push_data;
            r_mem_last[r_wr_ptr] <= w_push_last;
            r_mem_idx[r_wr_ptr]  <= w_grant;
        end
    end

    assign valid_o  = (r_count != '0);
    assign data_o   = valid_o ? r_mem_data[r_rd_ptr] : '0;
    assign last_o   = valid_o ? r_mem_last[r_rd_ptr] : 1'b0;
    assign idx_o    = valid_o ? r_mem_idx[r_rd_ptr] : '0;
    assign locked_o = (r_state == c_LOCKED);

endmodule
`default_nettype wire

// File: tb/tb_axi_slice_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_slice_rr_arbiter
// Brief    : Directed self-checking bench with a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_slice_rr_arbiter;

    localparam int N     = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 2;
    localparam int IW    = 2;

    logic            clk = 1'b0;
    logic            rst_i = 1'b1;
    logic [N-1:0]    req_valid_i = '0;
    logic [N-1:0]    req_ready_o;
    logic [N*DW-1:0] req_data_i = '0;
    logic [N-1:0]    req_last_i = '0;
    logic            valid_o;
    logic            ready_i = 1'b1;
    logic [DW-1:0]   data_o;
    logic            last_o;
    logic [IW-1:0]   idx_o;
    logic            locked_o;

    axi_slice_rr_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .BUFFER_DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_data_i(req_data_i), .req_last_i(req_last_i),
        .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o),
        .last_o(last_o), .idx_o(idx_o), .locked_o(locked_o)
    );

    always #5 clk = ~clk;

    typedef struct { int rid; logic [DW-1:0] d; logic l; } stim_t;
    typedef struct { logic [DW-1:0] d; logic l; int idx; } beat_t;

    stim_t  sq[$];
    beat_t  m_q[$];
    int     out_log[$];
    bit     m_locked = 0;
    int     m_owner = 0;
    int     m_rr = 0;
    bit     chk_en = 0;
    logic [N-1:0] hs_q = '0;
    int     hs_cnt = 0;
    int     lock_cyc = 0;
    int     errors = 0;
    int     checks = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic void apply_inputs();
        logic [N-1:0]    v = '0;
        logic [N*DW-1:0] d = '0;
        logic [N-1:0]    l = '0;
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < sq.size(); k++) begin
                if (sq[k].rid == i) begin
                    v[i] = 1'b1;
                    d[i*DW +: DW] = sq[k].d;
                    l[i] = sq[k].l;
                    break;
                end
            end
        end
        req_valid_i = v;
        req_data_i  = d;
        req_last_i  = l;
    endfunction

    function automatic void add(input int rid, input logic [DW-1:0] d, input logic l);
        stim_t s;
        s.rid = rid; s.d = d; s.l = l;
        sq.push_back(s);
    endfunction

    function automatic bit has_rid(input int rid);
        for (int k = 0; k < sq.size(); k++) if (sq[k].rid == rid) return 1'b1;
        return 1'b0;
    endfunction

    // Requesters retire their head beat the cycle after a handshake.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < N; i++) begin
            if (hs_q[i]) begin
                for (int k = 0; k < sq.size(); k++) begin
                    if (sq[k].rid == i) begin
                        sq.delete(k);
                        break;
                    end
                end
            end
        end
        apply_inputs();
    end

    // Reference model and per-cycle compare.
    always @(negedge clk) begin
        int g;
        logic [N-1:0] er;
        bit push, pop;
        beat_t b;
        hs_q = req_valid_i & req_ready_o;
        if (hs_q != '0) hs_cnt++;
        if (chk_en) begin
            g  = -1;
            er = '0;
            if (!rst_i) begin
                if (m_locked) g = m_owner;
                else begin
                    for (int k = 0; k < N; k++) begin
                        if (req_valid_i[(m_rr + k) % N]) begin
                            g = (m_rr + k) % N;
                            break;
                        end
                    end
                end
                if (g >= 0 && m_q.size() < DEPTH) er[g] = 1'b1;
            end
            chk("ready", req_ready_o, er);
            chk("locked", locked_o, m_locked);
            chk("valid", valid_o, m_q.size() > 0);
            if (m_q.size() > 0) begin
                chk("data", data_o, m_q[0].d);
                chk("last", last_o, m_q[0].l);
                chk("idx", idx_o, m_q[0].idx);
            end
            if (locked_o) lock_cyc++;
            if (valid_o && ready_i) out_log.push_back(int'(idx_o));
            pop  = (m_q.size() > 0) && ready_i;
            push = (g >= 0) && er[g] && req_valid_i[g];
            if (pop) void'(m_q.pop_front());
            if (push) begin
                b.d = req_data_i[g*DW +: DW]; b.l = req_last_i[g]; b.idx = g;
                m_q.push_back(b);
                if (b.l) begin
                    m_locked = 0;
                    m_rr = (g + 1) % N;
                end else begin
                    m_locked = 1;
                    m_owner = g;
                end
            end
            if (rst_i) begin
                m_q.delete();
                m_locked = 0;
                m_owner = 0;
                m_rr = 0;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while ((sq.size() > 0 || m_q.size() > 0) && n < 300) begin
            step(1);
            n++;
        end
        if (n >= 300) chk({nm, " drain timeout"}, 1, 0);
    endtask

    task automatic chk_seq(input string nm, input int start, input int n, input logic [31:0] exp);
        logic [3:0] e;
        chk({nm, " len"}, out_log.size() - start, n);
        for (int k = 0; k < n; k++) begin
            e = exp[4*(n-1-k) +: 4];
            if (start + k < out_log.size()) chk(nm, out_log[start + k], e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int mark, lmark, hmark, n;
        apply_inputs();
        step(2);
        chk_en = 1;
        chk("rst valid_o", valid_o, 0);
        chk("rst data_o", data_o, 0);
        chk("rst last_o", last_o, 0);
        chk("rst idx_o", idx_o, 0);
        chk("rst locked_o", locked_o, 0);

        // Single-beat bursts from everyone, presented while reset is still high.
        mark = out_log.size();
        for (int i = 0; i < N; i++) add(i, 32'hA0 + i, 1'b1);
        add(0, 32'hA4, 1'b1);
        apply_inputs();
        #1;
        chk("rst ready gated", req_ready_o, 0);
        step(1);
        rst_i = 1'b0;
        drain("B");
        chk_seq("B order", mark, 5, 32'h01230);

        // Requester 1 bursts 3 beats while requester 2 waits.
        mark = out_log.size();
        lmark = lock_cyc;
        add(1, 32'hB1, 1'b0); add(1, 32'hB2, 1'b0); add(1, 32'hB3, 1'b1);
        add(2, 32'hC0, 1'b1);
        apply_inputs();
        drain("C");
        chk_seq("C order", mark, 4, 32'h1112);
        chk("C lock cycles", lock_cyc - lmark, 2);

        // Downstream stall fills the buffer, then releases it.
        ready_i = 1'b0;
        mark = out_log.size();
        hmark = hs_cnt;
        add(3, 32'hD0, 1'b0); add(3, 32'hD1, 1'b0); add(3, 32'hD2, 1'b1);
        apply_inputs();
        step(6);
        chk("D accepted", hs_cnt - hmark, 2);
        chk("D ready when full", req_ready_o, 0);
        chk("D locked", locked_o, 1);
        chk("D head idx", idx_o, 3);
        chk("D head data", data_o, 32'hD0);
        ready_i = 1'b1;
        #1;
        chk("D no push on pop cycle", req_ready_o, 0);
        step(1);
        chk("D ready after pop", req_ready_o, 4'b1000);
        drain("D");
        chk_seq("D order", mark, 3, 32'h333);

        // Reset while requester 3 holds the lock with one buffered beat.
        add(1, 32'hE0, 1'b1);
        apply_inputs();
        drain("E0");
        ready_i = 1'b0;
        add(3, 32'hE1, 1'b0);
        apply_inputs();
        n = 0;
        while (has_rid(3) && n < 50) begin
            step(1);
            n++;
        end
        chk("E lock wait timeout", n >= 50, 0);
        chk("E locked before rst", locked_o, 1);
        chk("E valid before rst", valid_o, 1);
        rst_i = 1'b1;
        step(1);
        rst_i = 1'b0;
        chk("E valid after rst", valid_o, 0);
        chk("E locked after rst", locked_o, 0);
        ready_i = 1'b1;
        mark = out_log.size();
        add(0, 32'hE2, 1'b1); add(2, 32'hE3, 1'b1);
        apply_inputs();
        drain("E");
        chk_seq("E order", mark, 2, 32'h02);

        // Wrap-around search: rr_ptr=3, only requester 2 valid.
        mark = out_log.size();
        add(2, 32'hF0, 1'b1);
        apply_inputs();
        drain("F0");
        add(3, 32'hF1, 1'b1); add(0, 32'hF2, 1'b1);
        apply_inputs();
        drain("F");
        chk_seq("F order", mark, 3, 32'h230);

        step(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
